// File: rtl/mult_div_pkg.sv
// Shared definitions for the MULT/DIV sequencer: opcode classes, FSM states
// and the iteration counter sizing helper.
package mult_div_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_div_sequencer.sv
// Multicycle MIPS MULT/DIV unit: radix-2 Booth multiply and restoring divide
// sharing one 2W+1-bit shift register and one W+1-bit adder/subtractor.
module mult_div_sequencer
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam int unsigned     ACC_W    = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   opd_q, opd_d;     // multiplicand (MULT) or |divisor| (DIV)
    logic               rem_neg_q, rem_neg_d;
    logic               quo_neg_q, quo_neg_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic [WIDTH:0]     alu_x, alu_y, alu_sum, div_rem_sh;
    logic               alu_sub;
    logic [WIDTH-1:0]   abs_a, abs_b;

    always_comb begin
        abs_a = a[WIDTH-1] ? -a : a;
        abs_b = b[WIDTH-1] ? -b : b;
    end

    // Booth works on the sign-extended upper half so that subtracting the most
    // negative multiplicand cannot overflow; DIV trial-subtracts from the
    // remainder after its left shift.
    always_comb begin
        div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        alu_x      = '0;
        alu_y      = '0;
        alu_sub    = 1'b0;
        if (op_q == OP_MULT) begin
            alu_x = {acc_q[ACC_W-1], acc_q[ACC_W-1:WIDTH+1]};
            alu_y = {opd_q[WIDTH-1], opd_q};
            case (acc_q[1:0])
                2'b01:   alu_sub = 1'b0;
                2'b10:   alu_sub = 1'b1;
                default: alu_y   = '0;
            endcase
        end else begin
            alu_x   = div_rem_sh;
            alu_y   = {1'b0, opd_q};
            alu_sub = 1'b1;
        end
        alu_sum = alu_x + (alu_y ^ {(WIDTH+1){alu_sub}}) + {{WIDTH{1'b0}}, alu_sub};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opd_d     = opd_q;
        rem_neg_d = rem_neg_q;
        quo_neg_d = quo_neg_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    if (op == OP_MULT) begin
                        opd_d   = a;
                        acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
                        state_d = S_RUN;
                    end else if (b == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        opd_d     = abs_b;
                        rem_neg_d = a[WIDTH-1];
                        quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                        acc_d     = {{(WIDTH+1){1'b0}}, abs_a};
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (op_q == OP_MULT) begin
                    acc_d = {alu_sum, acc_q[WIDTH:1]};
                end else if (alu_sum[WIDTH]) begin
                    acc_d = {1'b0, div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {1'b0, alu_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q == OP_MULT) begin
                    {hi_d, lo_d} = acc_q[ACC_W-1:1];
                end else begin
                    lo_d = quo_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            opd_q     <= '0;
            rem_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opd_q     <= opd_d;
            rem_neg_q <= rem_neg_d;
            quo_neg_q <= quo_neg_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: stimulus pushes expected results,
// a monitor pops and checks them on every done pulse.
module tb_mult_div_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    mult_div_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int unsigned  n0;
        int unsigned  k;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_zero", 64'(div_zero), 64'(e.dz));
                check("done_cycle", 64'(cyc - e.n0 + 1), 64'(e.k));
            end
        end
    end

    task automatic issue(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic edz, input int unsigned ek);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        if (push) begin
            e.hi = eh; e.lo = el; e.dz = edz; e.n0 = cyc + 1; e.k = ek;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    endtask

    task automatic wait_idle(input string name, input int unsigned exp_busy);
        int unsigned n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, 64'(n), 64'(exp_busy));
    endtask

    task automatic run_op(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        issue(o, aa, bb, 1'b1, eh, el, 1'b0, 34);
        wait_idle("busy_cycles", 34);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op(1'b1, 32'h0000_2211, 32'h0000_0100, 32'h0000_0011, 32'h0000_0022);

        // Divide by zero: immediate done with flag, HI/LO untouched.
        issue(1'b1, 32'd5, 32'd0, 1'b1, 32'h11, 32'h22, 1'b1, 1);
        wait_idle("dz_busy_cycles", 1);
        check("dz_cleared", 64'(div_zero), 64'd0);
        check("dz_hi_kept", 64'(hi), 64'h11);
        check("dz_lo_kept", 64'(lo), 64'h22);
        @(negedge clk);

        // A start pulse while busy must be dropped.
        issue(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignored_busy_cycles", 29);
        repeat (3) @(negedge clk);
        check("ignored_no_restart", 64'(busy), 64'd0);

        // Reset in cycle 10 of a MULT: no done, HI/LO cleared.
        issue(1'b0, 32'd5, 32'd6, 1'b0, '0, '0, 1'b0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        repeat (30) @(negedge clk);
        check("midrst_idle", 64'(busy), 64'd0);

        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
